// File: rtl/multi_digit_counter_display_if.sv
// Bundle of the strobe inputs and the count/segment outputs of multi_digit_counter_display.
// The width follows the digit count, so instantiate it with the same NUM_DIGITS as the counter.
interface multi_digit_counter_display_if #(
    parameter int NUM_DIGITS = 2
);
    logic                    i_Inc;
    logic                    i_Dec;
    logic                    i_Clr;
    logic [4*NUM_DIGITS-1:0] o_Count;
    logic [7*NUM_DIGITS-1:0] o_Segments;
    logic                    o_Limit;
    logic                    o_At_Zero;
    logic                    o_At_Max;

    modport master (
        output i_Inc, i_Dec, i_Clr,
        input  o_Count, o_Segments, o_Limit, o_At_Zero, o_At_Max
    );

    modport slave (
        input  i_Inc, i_Dec, i_Clr,
        output o_Count, o_Segments, o_Limit, o_At_Zero, o_At_Max
    );
endinterface

// File: rtl/multi_digit_counter_display.sv
// Multi-digit up/down counter driven by debounced button strobes, with a registered
// per-digit seven-segment decoder, optional leading-zero blanking and wrap/saturate limits.
module multi_digit_counter_display #(
    parameter int NUM_DIGITS     = 2,
    parameter int RADIX          = 16,
    parameter int WRAP           = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 0
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    multi_digit_counter_display_if.slave  bus
);
    localparam int              CW        = 4 * NUM_DIGITS;
    localparam int              SW        = 7 * NUM_DIGITS;
    localparam logic [3:0]      DIGIT_MAX = 4'(RADIX - 1);
    localparam logic [CW-1:0]   COUNT_MAX = {NUM_DIGITS{DIGIT_MAX}};

    function automatic logic [6:0] glyph(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'b1111110;
            4'h1:    pattern = 7'b0110000;
            4'h2:    pattern = 7'b1101101;
            4'h3:    pattern = 7'b1111001;
            4'h4:    pattern = 7'b0110011;
            4'h5:    pattern = 7'b1011011;
            4'h6:    pattern = 7'b1011111;
            4'h7:    pattern = 7'b1110000;
            4'h8:    pattern = 7'b1111111;
            4'h9:    pattern = 7'b1111011;
            4'hA:    pattern = 7'b1110111;
            4'hB:    pattern = 7'b0011111;
            4'hC:    pattern = 7'b1001110;
            4'hD:    pattern = 7'b0111101;
            4'hE:    pattern = 7'b1001111;
            default: pattern = 7'b1000111;
        endcase
        return pattern;
    endfunction

    // Walk from the top digit down so "this and every higher digit is zero" accumulates.
    function automatic logic [SW-1:0] decode(input logic [CW-1:0] count);
        logic [SW-1:0] segs;
        logic          upperZero;
        segs      = '0;
        upperZero = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            upperZero = upperZero && (count[4*d +: 4] == 4'd0);
            if ((BLANK_LEADING != 0) && (d > 0) && upperZero) begin
                segs[7*d +: 7] = 7'b0000000;
            end else begin
                segs[7*d +: 7] = glyph(count[4*d +: 4]);
            end
        end
        if (SEG_ACTIVE_LOW != 0) begin
            segs = ~segs;
        end
        return segs;
    endfunction

    function automatic logic [CW-1:0] stepUp(input logic [CW-1:0] count);
        logic [CW-1:0] result;
        logic          carry;
        result = count;
        carry  = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (count[4*d +: 4] == DIGIT_MAX) begin
                    result[4*d +: 4] = 4'd0;
                end else begin
                    result[4*d +: 4] = count[4*d +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

    function automatic logic [CW-1:0] stepDown(input logic [CW-1:0] count);
        logic [CW-1:0] result;
        logic          borrow;
        result = count;
        borrow = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (borrow) begin
                if (count[4*d +: 4] == 4'd0) begin
                    result[4*d +: 4] = DIGIT_MAX;
                end else begin
                    result[4*d +: 4] = count[4*d +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end
        end
        return result;
    endfunction

    logic          r_IncPrev;
    logic          r_DecPrev;
    logic          r_ClrPrev;
    logic [CW-1:0] r_Count;
    logic          r_Limit;
    logic [SW-1:0] r_Segments;

    logic          w_IncEdge;
    logic          w_DecEdge;
    logic          w_ClrEdge;
    logic          w_AtZero;
    logic          w_AtMax;
    logic [CW-1:0] w_CountUp;
    logic [CW-1:0] w_CountDown;
    logic [CW-1:0] w_CountNext;
    logic          w_LimitNext;

    // History registers reset high so a button already held at reset release is ignored.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_IncPrev <= 1'b1;
            r_DecPrev <= 1'b1;
            r_ClrPrev <= 1'b1;
        end else begin
            r_IncPrev <= bus.i_Inc;
            r_DecPrev <= bus.i_Dec;
            r_ClrPrev <= bus.i_Clr;
        end
    end

    assign w_IncEdge   = bus.i_Inc & ~r_IncPrev;
    assign w_DecEdge   = bus.i_Dec & ~r_DecPrev;
    assign w_ClrEdge   = bus.i_Clr & ~r_ClrPrev;
    assign w_AtZero    = (r_Count == '0);
    assign w_AtMax     = (r_Count == COUNT_MAX);
    assign w_CountUp   = stepUp(r_Count);
    assign w_CountDown = stepDown(r_Count);

    always_comb begin
        w_CountNext = r_Count;
        w_LimitNext = 1'b0;
        if (w_ClrEdge) begin
            w_CountNext = '0;
        end else if (w_IncEdge && !w_DecEdge) begin
            if (w_AtMax) begin
                w_LimitNext = 1'b1;
                w_CountNext = (WRAP != 0) ? '0 : COUNT_MAX;
            end else begin
                w_CountNext = w_CountUp;
            end
        end else if (w_DecEdge && !w_IncEdge) begin
            if (w_AtZero) begin
                w_LimitNext = 1'b1;
                w_CountNext = (WRAP != 0) ? COUNT_MAX : '0;
            end else begin
                w_CountNext = w_CountDown;
            end
        end
    end

    // Segments are decoded from the registered count, so they trail it by one cycle.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Count    <= '0;
            r_Limit    <= 1'b0;
            r_Segments <= decode('0);
        end else begin
            r_Count    <= w_CountNext;
            r_Limit    <= w_LimitNext;
            r_Segments <= decode(r_Count);
        end
    end

    assign bus.o_Count    = r_Count;
    assign bus.o_Segments = r_Segments;
    assign bus.o_Limit    = r_Limit;
    assign bus.o_At_Zero  = w_AtZero;
    assign bus.o_At_Max   = w_AtMax;
endmodule

// File: doc/multi_digit_counter_display.md
# multi_digit_counter_display

Parametrised up/down counter with a per-digit seven-segment decoder, driven by debounced push-button strobes and feeding the board's seven-segment displays. It generalises the two-digit hex press counter in several ways:
- fully synchronous edge detection;
- configurable digit count and radix (hex or BCD);
- increment, decrement and clear;
- wrap or saturate at the limits;
- selectable segment polarity;
- optional leading-zero blanking.

## Interface
- NUM_DIGITS, 2, number of display digits (1..4)
- RADIX, 16, per-digit radix; only 10 (BCD) or 16 (hex) legal
- WRAP, 1, 1 = wrap at limits, 0 = saturate
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0
- BLANK_LEADING, 0, 1 = blank leading zero digits (digit 0 never blanked)
- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Inc  in  1  debounced level, synchronous to i_Clk; rising edge = +1
- i_Dec  in  1  debounced level, synchronous to i_Clk; rising edge = -1
- i_Clr  in  1  debounced level, synchronous to i_Clk; rising edge = clear to 0
- o_Count  out  4*NUM_DIGITS  count, one nibble per digit, digit 0 in [3:0]
- o_Segments  out  7*NUM_DIGITS  segments; digit d in [7d+6:7d], bit order A(MSB)..G(LSB), polarity per SEG_ACTIVE_LOW
- o_Limit  out  1  one-cycle pulse when a step hits a limit (inc at max, dec at zero)
- o_At_Zero  out  1  o_Count == 0
- o_At_Max  out  1  every digit == RADIX-1

## Operation
- Edge detection:
  - A registered copy of each input is kept; an edge is input==1 while its previous copy==0.
  - Previous-copy registers reset to 1, so a level already held high at reset release does not count.
- Priority per cycle:
  - Clr edge overrides everything: count <= 0, no o_Limit.
  - Inc and Dec edges in the same cycle: no change, no o_Limit.
  - Inc edge alone: +1.
  - Dec edge alone: -1.
- Arithmetic:
  - Each digit counts 0..RADIX-1, with carry/borrow ripple through all digits in one cycle.
  - Decimal nibbles never hold 10..15.
- Limits:
  - Inc at max: WRAP=1 gives count <= 0; WRAP=0 holds max. Either way o_Limit pulses.
  - Dec at 0: WRAP=1 gives count <= max; WRAP=0 holds 0. Either way o_Limit pulses.
- Decode:
  - Standard glyphs 0-9, A, b, C, d, E, F.
  - Raw A..G patterns, active-high, before polarity: 0=1111110, 1=0110000, A=1110111, F=1000111.
  - SEG_ACTIVE_LOW inverts all bits.
- Blanking (BLANK_LEADING=1): digit d>0 shows all segments off when it and every higher digit are 0.
- Reset values:
  - o_Count=0, o_Limit=0, o_At_Zero=1, o_At_Max=0.
  - o_Segments = decode of 0 under current blanking/polarity.
  - Example, defaults: o_Segments = 14'b0000001_0000001.

## Timing
- Edge sampled at rising edge k (input low at k-1, high at k): o_Count, o_At_Zero, o_At_Max and o_Limit update at edge k.
- o_Segments is registered from o_Count and updates at edge k+1 (1-cycle decode latency).
- o_Limit is high for exactly one cycle per qualifying edge; a held input never re-triggers.
- Back-to-back edges on consecutive cycles are impossible for a single input (it needs a low cycle); alternating Inc/Dec edges on consecutive cycles are each applied.
- Asynchronous reset mid-operation forces all reset values immediately. The first edge counts only after the input is seen low, then high, post-release.
- Inputs are required synchronous and debounced upstream; the block performs no synchronisation or debounce.

## Test plan
- Reset, defaults: during and after reset, o_Count=0x00 and o_Segments=0000001_0000001. Assert i_Inc before release and hold it: no count.
- Defaults: 17 Inc pulses → o_Count=0x11. Continue to 255 total → 0xFF, o_At_Max=1. One more → 0x00 with a single o_Limit pulse; segments follow one cycle after o_Count.
- RADIX=10, NUM_DIGITS=3: 1000 Inc pulses wrap 999→000. Dec from 000 → 999 with o_Limit. No nibble ever exceeds 9.
- WRAP=0: Dec at 0 holds 0 and pulses o_Limit. Inc to max, then Inc holds max and pulses o_Limit.
- Simultaneous events:
  - Inc and Dec rising on the same edge: count unchanged.
  - Clr with Inc on the same edge: count=0, no o_Limit.
- BLANK_LEADING=1, NUM_DIGITS=4, count 0x0050: digits 3 and 2 all off, digit 1 shows "5", digit 0 shows "0". SEG_ACTIVE_LOW=0 inverts all patterns.
